// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single shared memory port. One transaction is outstanding at a time.
// Data requests win by default. Fetch wins once it has been passed over
// StarveLimit times in a row.
//
// Handshake semantics (all request/response channels): a transfer happens
// on a rising edge where valid && ready are both 1. The requester holds
// valid and payload stable until that edge. Ready may depend
// combinationally on valid. Responses have no ready and are single-cycle
// pulses.
module mem_arbiter #(
   parameter int Width       = 32,
   parameter int StarveLimit = 3
) (
   input  logic             clk,
   input  logic             rst,
   // fetch port
   input  logic             if_req_valid,
   output logic             if_req_ready,
   input  logic [Width-1:0] if_addr,
   output logic             if_rsp_valid,
   output logic [Width-1:0] if_rsp_data,
   // data port
   input  logic             dm_req_valid,
   output logic             dm_req_ready,
   input  logic [Width-1:0] dm_addr,
   input  logic [Width-1:0] dm_wdata,
   input  logic             dm_we,
   input  logic [3:0]       dm_be,
   output logic             dm_rsp_valid,
   output logic [Width-1:0] dm_rsp_data,
   // shared memory port
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [Width-1:0] mem_addr,
   output logic [Width-1:0] mem_wdata,
   output logic             mem_we,
   output logic [3:0]       mem_be,
   input  logic             mem_rsp_valid,
   input  logic [Width-1:0] mem_rsp_data,
   // observability
   output logic [1:0]       dbg_state,
   output logic [3:0]       dbg_starve_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IF = 2'd1,
      WAIT_DM = 2'd2
   } state_t;

   localparam logic [3:0] StarveMax = 4'(StarveLimit);

   state_t     state;
   logic       lock_valid;  // a request is presented but not yet accepted
   logic       lock_sel;    // locked selection: 1 = fetch, 0 = data
   logic [3:0] starve_cnt;

   logic sel_if;
   logic in_idle;
   logic accept;

   // Arbitration and request mux. A locked selection overrides fresh
   // arbitration so the presented request never changes before acceptance.
   always_comb begin
      sel_if        = 1'b0;
      in_idle       = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_we        = 1'b0;
      mem_be        = 4'h0;
      if_req_ready  = 1'b0;
      dm_req_ready  = 1'b0;
      accept        = 1'b0;

      if (lock_valid) begin
         sel_if = lock_sel;
      end else begin
         sel_if = if_req_valid && (!dm_req_valid || (starve_cnt == StarveMax));
      end

      in_idle = (state == IDLE) && !rst;

      if (sel_if) begin
         mem_addr  = if_addr;
         mem_wdata = '0;
         mem_we    = 1'b0;
         mem_be    = 4'hF;
      end else begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         mem_we    = dm_we;
         mem_be    = dm_be;
      end

      if (in_idle) begin
         mem_req_valid = sel_if ? if_req_valid : dm_req_valid;
         if_req_ready  = sel_if && mem_req_ready;
         dm_req_ready  = !sel_if && mem_req_ready;
      end

      accept = mem_req_valid && mem_req_ready;
   end

   // Zero-latency response steering to whichever port owns the transaction.
   always_comb begin
      if_rsp_valid = !rst && (state == WAIT_IF) && mem_rsp_valid;
      dm_rsp_valid = !rst && (state == WAIT_DM) && mem_rsp_valid;
      if_rsp_data  = mem_rsp_data;
      dm_rsp_data  = mem_rsp_data;
   end

   // Transaction FSM, selection lock and fetch starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lock_valid <= 1'b0;
         lock_sel   <= 1'b0;
         starve_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= sel_if ? WAIT_IF : WAIT_DM;
                  lock_valid <= 1'b0;
                  if (sel_if || !if_req_valid) begin
                     starve_cnt <= 4'd0;
                  end else if (starve_cnt >= StarveMax) begin
                     starve_cnt <= StarveMax;
                  end else begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end else if (mem_req_valid) begin
                  lock_valid <= 1'b1;
                  lock_sel   <= sel_if;
               end
            end
            WAIT_IF, WAIT_DM: begin
               // The response cycle itself never issues a new request.
               if (mem_rsp_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: Width, 32, address/data width (matches rvcpu::Width).
REQ-002 Parameter: StarveLimit, 3, max consecutive data-port grants while fetch waits (1..15).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; the ports are listed below.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 if_req_valid/if_req_ready  in/out  1/1  fetch request handshake.
REQ-007 if_addr  in  Width  fetch address.
REQ-008 if_rsp_valid/if_rsp_data  out/out  1/Width  fetch response.
REQ-009 dm_req_valid/dm_req_ready  in/out  1/1  data request handshake.
REQ-010 dm_addr, dm_wdata  in  Width  data address and write data.
REQ-011 dm_we, dm_be  in  1, 4  write enable and byte enables.
REQ-012 dm_rsp_valid/dm_rsp_data  out/out  1/Width  data response (loads and store acks).
REQ-013 mem_req_valid/mem_req_ready  out/in  1/1  shared memory request handshake.
REQ-014 mem_addr, mem_wdata  out  Width;  mem_we, mem_be  out  1, 4.
REQ-015 mem_rsp_valid/mem_rsp_data  in/in  1/Width  memory response; exactly one per accepted request, stores included.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_IF, WAIT_DM; one transaction outstanding, max.
REQ-017 IDLE: mem_req_valid = selected requester's valid; mem_addr/we/be/wdata mux from the selected port; if selected, mem_we=0, be=4'hF, wdata=0.
REQ-018 Selection: data port wins, except fetch wins when both valid and starve_cnt == StarveLimit.
REQ-019 Handshake: accept when mem_req_valid && mem_req_ready in IDLE; selected port's req_ready = mem_req_ready that cycle; other port's req_ready = 0.
REQ-020 Lock: if mem_req_valid asserted without mem_req_ready, selection SHALL be registered and held until acceptance, regardless of new requests from the other port.
REQ-021 On acceptance: IDLE -> WAIT_IF or WAIT_DM; lock cleared.
REQ-022 WAIT_x: mem_req_valid=0, both req_ready=0; x_rsp_valid = mem_rsp_valid, x_rsp_data = mem_rsp_data (zero-latency pass-through); other rsp_valid=0.
REQ-023 WAIT_x with mem_rsp_valid -> IDLE next cycle; no new request issued in the response cycle (min 2 cycles/transaction).
REQ-024 mem_rsp_valid in IDLE SHALL be ignored (both rsp_valid stay 0).
REQ-025 starve_cnt (4 bit): +1 (saturating at StarveLimit) on data grant with if_req_valid=1; cleared on fetch grant or on data grant with if_req_valid=0.
REQ-026 Requesters hold valid and payload stable until ready; arbiter need not tolerate withdrawal.

Reset
REQ-027 rst=1 SHALL force state=IDLE, lock cleared, starve_cnt=0 at next edge.
REQ-028 While rst=1: mem_req_valid, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid SHALL be 0.
REQ-029 Reset mid-transaction SHALL drop the outstanding response; a late mem_rsp_valid after reset is ignored per REQ-024.

Verification
REQ-030 Fetch only, if_addr=0x100, mem_req_ready=1, rsp 2 cycles later data 0xDEADBEEF -> if_rsp_valid one cycle with 0xDEADBEEF; dm_rsp_valid never set.
REQ-031 Both valid same cycle, starve_cnt=0 -> data granted first; fetch granted in IDLE after data response.
REQ-032 Data valid continuously, fetch valid, StarveLimit=3 -> grants D,D,D,F,D,... ; starve_cnt 0,1,2,3,0.
REQ-033 Fetch requested, mem_req_ready=0 for 3 cycles, dm_req_valid rises cycle 2 -> mem_addr stays if_addr; fetch accepted; dm_req_ready=0 throughout.
REQ-034 Store dm_we=1, be=4'b0011, wdata=0x1234 -> mem_we=1, mem_be=4'b0011, mem_wdata=0x1234; ack -> dm_rsp_valid=1.
REQ-035 rst in WAIT_DM, then mem_rsp_valid one cycle after release -> dm_rsp_valid=0, state IDLE, starve_cnt=0.
